// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU front end: instruction width,
// fetch-stage defaults and the fetch state encoding.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, single-outstanding memory fetch, one-entry IR.
// Optional INSTR_FETCH_PERF_EN adds the instr_count accepted-instruction counter.
//
// Handshakes: mem_req is a level held with a stable mem_addr until the cycle
// mem_ack is sampled high; instr_set transfers on any rising edge where
// instr_valid && instr_ready, and instr_valid only drops on transfer, redirect or reset.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr_set,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [15:0]        instr_count
`endif
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;

  assign pc_next = pc + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      instr_set   <= '0;
      instr_valid <= 1'b0;
      pc_out      <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          state   <= FETCH;
          mem_req <= 1'b1;
          if (redirect) begin
            pc       <= redirect_pc;
            mem_addr <= redirect_pc;
          end else begin
            mem_addr <= pc;
          end
        end

        FETCH: begin
          if (mem_ack && redirect) begin
            // Returned word is stale; issue the redirected fetch straight away.
            pc       <= redirect_pc;
            mem_addr <= redirect_pc;
          end else if (mem_ack) begin
            instr_set   <= mem_rdata;
            pc_out      <= pc;
            pc          <= pc_next;
            instr_valid <= 1'b1;
            mem_req     <= 1'b0;
            state       <= FULL;
          end else if (redirect) begin
            // The request cannot be withdrawn, so keep it up and drop its data later.
            pc    <= redirect_pc;
            state <= DRAIN;
          end
        end

        FULL: begin
          if (redirect) begin
            instr_valid <= 1'b0;
            pc          <= redirect_pc;
            mem_addr    <= redirect_pc;
            mem_req     <= 1'b1;
            state       <= FETCH;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            mem_addr    <= pc;
            mem_req     <= 1'b1;
            state       <= FETCH;
          end
        end

        DRAIN: begin
          if (redirect) begin
            pc <= redirect_pc;
          end
          if (mem_ack) begin
            mem_addr <= redirect ? redirect_pc : pc;
            state    <= FETCH;
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef INSTR_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= 16'h0000;
    end else if (instr_valid && instr_ready) begin
      instr_count <= instr_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed sequences, a redirect vector
// table and a randomized phase checked against a stream-level fetch model.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instr_set;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc_out;
  logic        redirect;
  logic [15:0] redirect_pc;
`ifdef INSTR_FETCH_PERF_EN
  logic [15:0] instr_count;
`endif

  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_set   (instr_set),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_out      (pc_out),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef INSTR_FETCH_PERF_EN
    ,
    .instr_count (instr_count)
`endif
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] t;
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0001) return 16'h5678;
    t = a * 16'h9E37;
    return t ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!instr_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: instr_valid timeout got 0 expected 1", name);
    end
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    @(negedge clk);
    while (!mem_ack && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!mem_ack) begin
      checks++;
      errors++;
      $display("FAIL %s: mem_ack timeout got 0 expected 1", name);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " mem_req"}, 32'(mem_req), 32'h0);
    check({name, " mem_addr"}, 32'(mem_addr), 32'h0);
    check({name, " instr_set"}, 32'(instr_set), 32'h0);
    check({name, " instr_valid"}, 32'(instr_valid), 32'h0);
    check({name, " pc_out"}, 32'(pc_out), 32'h0);
`ifdef INSTR_FETCH_PERF_EN
    check({name, " instr_count"}, 32'(instr_count), 32'h0);
`endif
  endtask

  // ---------------- memory responder ----------------
  int          mem_lat  = 1;
  bit          rand_lat = 1'b0;
  bit          pend     = 1'b0;
  int          cnt      = 0;
  logic [15:0] req_addr = '0;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("mem hold req", 32'(mem_req), 32'h1);
          check("mem hold addr", 32'(mem_addr), 32'(req_addr));
        end else if (mem_req) begin
          pend     = 1'b1;
          req_addr = mem_addr;
          cnt      = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
        end
        if (pend) begin
          cnt--;
          if (cnt <= 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_word(req_addr);
            pend      = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stream reference model ----------------
  // Accepted instructions must come from consecutive addresses starting at the
  // reset PC or at the most recent redirect target.
  bit          model_en = 1'b0;
  logic [15:0] exp_pc   = '0;
  logic [15:0] exp_q[$];
  int          rand_acc = 0;
  bit          prev_valid = 1'b0;
  bit          prev_accept = 1'b0;
  bit          prev_redirect = 1'b0;
  logic [15:0] perf_model = '0;

  always @(negedge clk) begin
    if (!rst_n) perf_model = '0;
    else if (instr_valid && instr_ready) perf_model = perf_model + 16'h1;
  end

  always @(negedge clk) begin
    if (model_en && rst_n) begin
      if (prev_valid && !prev_accept && !prev_redirect)
        check("model valid held", 32'(instr_valid), 32'h1);
      if (prev_redirect)
        check("model valid after redirect", 32'(instr_valid), 32'h0);
      if (instr_valid && instr_ready) begin
        exp_q.push_back(exp_pc);
        exp_pc = exp_pc + 16'h1;
      end
      if (instr_valid && instr_ready) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("model pc_out", 32'(pc_out), 32'(e));
        check("model instr_set", 32'(instr_set), 32'(mem_word(e)));
        rand_acc++;
      end
      if (redirect) exp_pc = redirect_pc;
      prev_valid    = instr_valid;
      prev_accept   = instr_valid && instr_ready;
      prev_redirect = redirect;
    end
  end

  // ---------------- redirect vector table ----------------
  typedef struct {
    bit          in_full;   // 0: redirect with ack in FETCH, 1: redirect in FULL with ready
    logic [15:0] rpc;
    int          lat;
    logic [15:0] exp_pc_out;
    logic [15:0] exp_next;
  } vec_t;

  vec_t vecs[5];

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] hold_set;
    rst_n       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    vecs[0] = '{1'b0, 16'h0010, 1, 16'h0010, 16'h0011};
    vecs[1] = '{1'b1, 16'h0010, 2, 16'h0010, 16'h0011};
    vecs[2] = '{1'b0, 16'hFFFF, 1, 16'hFFFF, 16'h0000};
    vecs[3] = '{1'b1, 16'hFFFF, 3, 16'hFFFF, 16'h0000};
    vecs[4] = '{1'b0, 16'h8000, 2, 16'h8000, 16'h8001};

    // Reset values and basic two-word fetch
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    instr_ready = 1'b1;
    mem_lat     = 1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    wait_valid("t1 first");
    check("t1 instr_set 0", 32'(instr_set), 32'h1234);
    check("t1 pc_out 0", 32'(pc_out), 32'h0);
    check("t1 mem_req low in FULL", 32'(mem_req), 32'h0);
    @(negedge clk);
    check("t1 refetch req", 32'(mem_req), 32'h1);
    check("t1 refetch addr", 32'(mem_addr), 32'h1);
    check("t1 valid cleared", 32'(instr_valid), 32'h0);
    wait_valid("t1 second");
    check("t1 instr_set 1", 32'(instr_set), 32'h5678);
    check("t1 pc_out 1", 32'(pc_out), 32'h1);

    // Backpressure for 5 cycles
    instr_ready = 1'b0;
    hold_set    = instr_set;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp valid", 32'(instr_valid), 32'h1);
      check("bp instr_set", 32'(instr_set), 32'(hold_set));
      check("bp pc_out", 32'(pc_out), 32'h1);
      check("bp mem_req", 32'(mem_req), 32'h0);
    end

    // Redirect while a slow fetch of address 2 is outstanding
    mem_lat     = 3;
    instr_ready = 1'b1;
    @(negedge clk);
    check("drain req", 32'(mem_req), 32'h1);
    check("drain addr2", 32'(mem_addr), 32'h2);
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    redirect = 1'b0;
    for (int i = 0; i < 10 && !mem_ack; i++) begin
      check("drain stale req", 32'(mem_req), 32'h1);
      check("drain stale addr", 32'(mem_addr), 32'h2);
      @(negedge clk);
    end
    check("drain ack seen", 32'(mem_ack), 32'h1);
    check("drain no valid", 32'(instr_valid), 32'h0);
    @(negedge clk);
    check("drain new req", 32'(mem_req), 32'h1);
    check("drain new addr", 32'(mem_addr), 32'h0040);
    check("drain still invalid", 32'(instr_valid), 32'h0);
    wait_valid("drain target");
    check("drain pc_out", 32'(pc_out), 32'h0040);
    check("drain instr_set", 32'(instr_set), 32'(mem_word(16'h0040)));
    @(negedge clk);

    // Table: redirect coincident with ack, or in FULL with ready
    for (int v = 0; v < 5; v++) begin
      mem_lat = vecs[v].lat;
      if (vecs[v].in_full) wait_valid("vec full");
      else wait_ack("vec ack");
      redirect    = 1'b1;
      redirect_pc = vecs[v].rpc;
      @(negedge clk);
      redirect = 1'b0;
      check("vec stale dropped", 32'(instr_valid), 32'h0);
      check("vec redirect req", 32'(mem_req), 32'h1);
      check("vec redirect addr", 32'(mem_addr), 32'(vecs[v].rpc));
      wait_valid("vec target");
      check("vec pc_out", 32'(pc_out), 32'(vecs[v].exp_pc_out));
      check("vec instr_set", 32'(instr_set), 32'(mem_word(vecs[v].exp_pc_out)));
      @(negedge clk);
      check("vec next req", 32'(mem_req), 32'h1);
      check("vec next addr", 32'(mem_addr), 32'(vecs[v].exp_next));
    end

    // Asynchronous reset in the middle of a fetch
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async reset");
    repeat (2) @(negedge clk);
    mem_lat = 1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_valid("post reset 0");
    check("post reset pc_out", 32'(pc_out), 32'h0);
    check("post reset instr_set", 32'(instr_set), 32'h1234);
    wait_valid("post reset 1");
    wait_valid("post reset 2");
    check("post reset third pc_out", 32'(pc_out), 32'h2);
    @(negedge clk);
`ifdef INSTR_FETCH_PERF_EN
    check("perf count 3", 32'(instr_count), 32'h3);
    #2 rst_n = 1'b0;
    #1 check("perf count reset", 32'(instr_count), 32'h0);
`else
    #2 rst_n = 1'b0;
`endif

    // Randomized phase against the stream model
    repeat (2) @(negedge clk);
    exp_pc   = 16'h0000;
    exp_q.delete();
    rand_lat = 1'b1;
    model_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFFE + 16'($urandom_range(0, 1));
      else redirect_pc = 16'($urandom_range(0, 65535));
    end
    @(posedge clk);
    #1 redirect = 1'b0;
    @(posedge clk);
    #2;
    model_en = 1'b0;
    check("random progress", 32'(rand_acc > 40), 32'h1);
`ifdef INSTR_FETCH_PERF_EN
    check("perf count random", 32'(instr_count), 32'(perf_model));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
